ysyx_23060184_lsu: RTL and testbench



---
 rtl/ysyx_23060184_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_23060184_lsu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_lsu
//
// Load/store unit between the execute stage and data memory. It accepts one
// operation at a time from execute (in_valid/in_ready). It then runs a single
// request/response exchange with data memory (req_*/resp_*). Finally it hands
// the formatted load value, or a plain completion, to writeback
// (out_valid/out_ready).
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid / in_ready       execute-side handshake (ready only in IDLE)
//   MemRead, MemWrite         operation kind (00 = non-memory, 1x/x1 store wins)
//   funct3                    access size / signedness
//   ALUResult                 byte address
//   RD2                       store data
//   req_valid / req_ready     memory request handshake
//   req_addr                  word-aligned address
//   req_wen                   1 = write
//   req_wdata, req_wmask      lane-replicated store data and byte enables
//   resp_valid / resp_ready   memory response handshake
//   resp_rdata, resp_err      raw read word and access fault
//   out_valid / out_ready     writeback handshake
//   ReadData                  formatted load result (0 for stores/non-memory)
//   out_err                   bus error or misalignment fault
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   When defined, misaligned halfword/word accesses complete immediately
//   with out_err=1 and never reach memory. When undefined, every memory op
//   issues a request. Misaligned accesses then use the truncated lane mask.
// ---------------------------------------------------------------------------
module ysyx_23060184_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] RD2,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_WIDTH-1:0] req_addr,
    output logic                  req_wen,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wmask,
    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [DATA_WIDTH-1:0] resp_rdata,
    input  logic                  resp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic       is_store;
    logic [2:0] f3_q;
    logic [1:0] off_q;

    // Shift the addressed byte lane down to bit 0, then size/sign-extend.
    function automatic logic [DATA_WIDTH-1:0] load_format(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [2:0]            f3,
        input logic [1:0]            off
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_format = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  load_format = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100:  load_format = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  load_format = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: load_format = sh;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the mask alone selects
    // which bytes memory writes.
    function automatic logic [DATA_WIDTH-1:0] store_wdata(
        input logic [DATA_WIDTH-1:0] rd2,
        input logic [2:0]            f3
    );
        case (f3)
            3'b000:  store_wdata = {4{rd2[7:0]}};
            3'b001:  store_wdata = {2{rd2[15:0]}};
            default: store_wdata = rd2;
        endcase
    endfunction

    // Shifting inside a 4-bit variable drops lanes past byte 3 for misaligned
    // halfwords.
    function automatic logic [3:0] store_wmask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b0001 << off;
            3'b001:  m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        store_wmask = m;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    // Halfword needs addr[0]=0; anything not byte/halfword is a word access.
    function automatic logic misaligned(
        input logic       store,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic half, byte_acc;
        byte_acc = store ? (f3 == 3'b000) : (f3 == 3'b000 || f3 == 3'b100);
        half     = store ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        if (byte_acc)  misaligned = 1'b0;
        else if (half) misaligned = off[0];
        else           misaligned = (off != 2'b00);
    endfunction
`endif

    // Handshake outputs are pure state decodes, so no input reaches them
    // combinationally.
    assign in_ready   = (state == IDLE);
    assign req_valid  = (state == REQ);
    assign resp_ready = (state == RESP);
    assign out_valid  = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            req_addr  <= '0;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wmask <= 4'b0000;
            ReadData  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                // Accept: capture the whole operation and precompute the
                // request so it is held stable throughout REQ.
                IDLE: begin
                    if (in_valid) begin
                        is_store  <= MemWrite;
                        f3_q      <= funct3;
                        off_q     <= ALUResult[1:0];
                        req_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        req_wen   <= MemWrite;
                        req_wdata <= MemWrite ? store_wdata(RD2, funct3) : '0;
                        req_wmask <= MemWrite ? store_wmask(funct3, ALUResult[1:0]) : 4'b0000;
                        ReadData  <= '0;
                        out_err   <= 1'b0;
                        if (!(MemRead || MemWrite)) begin
                            state <= DONE;
`ifdef LSU_MISALIGN_CHECK_EN
                        end else if (misaligned(MemWrite, funct3, ALUResult[1:0])) begin
                            out_err <= 1'b1;
                            state   <= DONE;
`endif
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                // Request: wait for memory to accept; responses are ignored here.
                REQ: begin
                    if (req_ready) state <= RESP;
                end
                // Response: format the load (stores report zero) and latch the fault.
                RESP: begin
                    if (resp_valid) begin
                        ReadData <= is_store ? '0 : load_format(resp_rdata, f3_q, off_q);
                        out_err  <= resp_err;
                        state    <= DONE;
                    end
                end
                // Done: hold the result until writeback takes it.
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
module tb_ysyx_23060184_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, RD2;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        out_valid, out_ready;
    logic [31:0] ReadData;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;

    always #5 clk = ~clk;

    ysyx_23060184_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .RD2(RD2),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .ReadData(ReadData), .out_err(out_err)
    );

    // Count accepted memory requests.
    always @(posedge clk) begin
        if (rstn && req_valid && req_ready) n_req <= n_req + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one operation starting in IDLE (called #1 after a rising edge).
    // The caller supplies the hand-computed expected request and result.
    task automatic run_op(
        input string       name,
        input logic        mr, input logic mw, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] rd2,
        input logic [31:0] rdata, input logic err,
        input int          req_stall, input int out_stall,
        input logic        exp_req,
        input logic [31:0] exp_addr, input logic [3:0] exp_wmask,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_rd, input logic exp_err
    );
        int req0;
        req0 = n_req;
        check({name, ".in_ready"}, in_ready, 1);
        in_valid = 1; MemRead = mr; MemWrite = mw; funct3 = f3;
        ALUResult = addr; RD2 = rd2;
        step();
        in_valid = 0; MemRead = 0; MemWrite = 0; ALUResult = 32'h0; RD2 = 32'h0;
        check({name, ".in_ready_busy"}, in_ready, 0);
        if (exp_req) begin
            check({name, ".req_valid"}, req_valid, 1);
            check({name, ".req_addr"}, req_addr, exp_addr);
            check({name, ".req_wen"}, req_wen, mw);
            check({name, ".req_wmask"}, req_wmask, exp_wmask);
            if (mw) check({name, ".req_wdata"}, req_wdata, exp_wdata);
            // Stall the request; a stray response during REQ must be ignored.
            for (int i = 0; i < req_stall; i++) begin
                resp_valid = 1; resp_rdata = 32'hDEAD_DEAD; resp_err = 1;
                step();
                check({name, ".stall_req_valid"}, req_valid, 1);
                check({name, ".stall_req_addr"}, req_addr, exp_addr);
                check({name, ".stall_req_wmask"}, req_wmask, exp_wmask);
                check({name, ".stall_in_ready"}, in_ready, 0);
                check({name, ".stall_out_valid"}, out_valid, 0);
            end
            resp_valid = 0; resp_err = 0;
            req_ready = 1;
            step();
            req_ready = 0;
            check({name, ".req_dropped"}, req_valid, 0);
            check({name, ".resp_ready"}, resp_ready, 1);
            resp_valid = 1; resp_rdata = rdata; resp_err = err;
            step();
            resp_valid = 0; resp_rdata = 32'h0; resp_err = 0;
        end else begin
            check({name, ".no_req"}, req_valid, 0);
        end
        check({name, ".out_valid"}, out_valid, 1);
        check({name, ".ReadData"}, ReadData, exp_rd);
        check({name, ".out_err"}, out_err, exp_err);
        for (int i = 0; i < out_stall; i++) begin
            step();
            check({name, ".hold_out_valid"}, out_valid, 1);
            check({name, ".hold_ReadData"}, ReadData, exp_rd);
            check({name, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        check({name, ".back_idle"}, in_ready, 1);
        check({name, ".out_cleared"}, out_valid, 0);
        check({name, ".req_count"}, n_req - req0, exp_req ? 1 : 0);
    endtask

    initial begin
        rstn = 0; in_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 3'b000;
        ALUResult = 0; RD2 = 0; req_ready = 0; resp_valid = 0;
        resp_rdata = 0; resp_err = 0; out_ready = 0;
        step();
        step();
        check("rst.in_ready", in_ready, 1);
        check("rst.req_valid", req_valid, 0);
        check("rst.resp_ready", resp_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.ReadData", ReadData, 0);
        check("rst.out_err", out_err, 0);
        check("rst.req_wmask", req_wmask, 0);
        rstn = 1;
        step();

        //      name   mr mw f3      addr          rd2           rdata         err rs os req addr          mask     wdata         rd            err
        run_op("lb",   1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 0, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 0);
        run_op("lhu",  1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 0, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_BEEF, 0);
        run_op("sh",   0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0,        0);
        run_op("lwerr",1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'h1122_3344, 1, 0, 0, 1, 32'h0000_4000, 4'b0000, 32'h0,        32'h1122_3344, 1);
        run_op("sb",   0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0,        0, 0, 0, 1, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0);
        run_op("lh",   1, 0, 3'b001, 32'h0000_6000, 32'h0,        32'h1234_8001, 0, 0, 0, 1, 32'h0000_6000, 4'b0000, 32'h0,        32'hFFFF_8001, 0);
        run_op("lbu",  1, 0, 3'b100, 32'h0000_7002, 32'h0,        32'h00C3_0000, 0, 0, 0, 1, 32'h0000_7000, 4'b0000, 32'h0,        32'h0000_00C3, 0);
        run_op("nomem",0, 0, 3'b010, 32'h0000_7777, 32'h5555_5555, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
        run_op("bp_sw",0, 1, 3'b010, 32'h0000_8004, 32'hCAFE_BABE, 32'h0,        0, 3, 2, 1, 32'h0000_8004, 4'b1111, 32'hCAFE_BABE, 32'h0,        0);
        run_op("rw_st",1, 1, 3'b010, 32'h0000_9008, 32'h0102_0304, 32'h7777_7777, 0, 0, 0, 1, 32'h0000_9008, 4'b1111, 32'h0102_0304, 32'h0,        0);
`ifdef LSU_MISALIGN_CHECK_EN
        run_op("mis_lw",1, 0, 3'b010, 32'h0000_1002, 32'h0,       32'hAABB_CCDD, 0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        run_op("mis_sh",0, 1, 3'b001, 32'h0000_3003, 32'h0000_BEEF, 32'h0,       0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
`else
        run_op("mis_lw",1, 0, 3'b010, 32'h0000_1002, 32'h0,       32'hAABB_CCDD, 0, 0, 0, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_AABB, 0);
        run_op("mis_sh",0, 1, 3'b001, 32'h0000_3003, 32'h0000_BEEF, 32'h0,       0, 0, 0, 1, 32'h0000_3000, 4'b1000, 32'hBEEF_BEEF, 32'h0,        0);
`endif

        // Asynchronous reset while waiting for a response.
        in_valid = 1; MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUResult = 32'h0000_A000;
        step();
        in_valid = 0; MemRead = 0;
        req_ready = 1;
        step();
        req_ready = 0;
        check("rstmid.resp_ready", resp_ready, 1);
        #2;
        rstn = 0;
        #1;
        check("rstmid.in_ready", in_ready, 1);
        check("rstmid.req_valid", req_valid, 0);
        check("rstmid.out_valid", out_valid, 0);
        check("rstmid.resp_ready", resp_ready, 0);
        step();
        rstn = 1;
        step();
        check("rstmid.idle_after", in_ready, 1);
        run_op("post_rst_lw", 1, 0, 3'b010, 32'h0000_B00C, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 1, 32'h0000_B00C, 4'b0000, 32'h0, 32'h0BAD_F00D, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
